// File: rtl/fp_add_issuer_if.sv
// Request / adder / result signal bundle for fp_add_issuer.
// The design uses the slave modport; the surrounding system uses master.
`timescale 1ns/1ps
interface fp_add_issuer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_op;

    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_op;
    logic [31:0] add_res;
    logic        add_error;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic        out_error;
    logic        out_nan;

    logic        busy;

    modport slave (
        input  in_valid, in_a, in_b, in_op, add_res, add_error, out_ready,
        output in_ready, add_a, add_b, add_op, out_valid, out_res, out_error, out_nan, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_op, add_res, add_error, out_ready,
        input  in_ready, add_a, add_b, add_op, out_valid, out_res, out_error, out_nan, busy
    );
endinterface

// File: rtl/fp_add_issuer.sv
// Queues single-precision add/sub requests in a 2-entry FIFO and issues them one at a
// time to an iterative adder, holding operands stable; NaN operands bypass the adder.
`timescale 1ns/1ps
module fp_add_issuer #(
    parameter int unsigned HOLD_CYCLES = 32
) (
    input logic           clk,
    input logic           rst_n,
    fp_add_issuer_if.slave bus
);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
    } req_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        BYPASS = 2'd2,
        OUT    = 2'd3
    } state_t;

    localparam logic [5:0]  LAST_CNT = 6'(HOLD_CYCLES - 1);
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction

    state_t     state, state_next;
    req_t       mem [2];
    logic       wr_ptr, rd_ptr;
    logic [1:0] count, count_next;
    logic [5:0] cnt;
    logic       sample_due;
    logic       push, pop, load, cap_hold, cap_nan;
    req_t       head;
    logic       head_nan;

    assign push     = bus.in_valid && bus.in_ready;
    assign head     = mem[rd_ptr];
    assign head_nan = is_nan(head.a) || is_nan(head.b);
    assign bus.busy = (count != 2'd0) || (state != IDLE);

    always_comb begin
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // NOTE: FIFO storage has no reset; count alone defines emptiness, so stale data is never read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{a: bus.in_a, b: bus.in_b, op: bus.in_op};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        cap_hold   = 1'b0;
        cap_nan    = 1'b0;
        case (state)
            IDLE: begin
                if (count != 2'd0) begin
                    pop = 1'b1;
                    if (head_nan) begin
                        state_next = BYPASS;
                    end else begin
                        load       = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (sample_due) begin
                    cap_hold   = 1'b1;
                    state_next = OUT;
                end
            end
            BYPASS: begin
                cap_nan    = 1'b1;
                state_next = OUT;
            end
            OUT: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignment so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= 2'd0;
            bus.in_ready  <= 1'b0;
            cnt           <= 6'd0;
            sample_due    <= 1'b0;
            bus.add_a     <= 32'd0;
            bus.add_b     <= 32'd0;
            bus.add_op    <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_res   <= 32'd0;
            bus.out_error <= 1'b0;
            bus.out_nan   <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count        <= count_next;
            bus.in_ready <= (count_next != 2'd2);

            if (load) begin
                bus.add_a  <= head.a;
                bus.add_b  <= head.b;
                bus.add_op <= head.op;
                cnt        <= 6'd0;
            end else if (state == HOLD && cnt != LAST_CNT) begin
                cnt <= cnt + 6'd1;
            end

            // Sample one edge after terminal count: add_res then reflects a full hold window.
            sample_due <= (state == HOLD) && (cnt == LAST_CNT) && !sample_due;

            if (cap_hold) begin
                bus.out_res   <= bus.add_res;
                bus.out_error <= bus.add_error;
                bus.out_nan   <= 1'b0;
            end else if (cap_nan) begin
                bus.out_res   <= QNAN;
                bus.out_error <= 1'b0;
                bus.out_nan   <= 1'b1;
            end

            bus.out_valid <= (state_next == OUT);
        end
    end

endmodule

// File: tb/tb_fp_add_issuer.sv
// Directed bench for fp_add_issuer with a toy adder model driving add_res/add_error.
`timescale 1ns/1ps
module tb_fp_add_issuer;

    localparam int H = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic force_err = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    fp_add_issuer_if bus();

    fp_add_issuer #(.HOLD_CYCLES(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] adder_model(input logic [31:0] a, input logic [31:0] b, input logic op);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !op) return 32'h4040_0000;
        return a ^ b ^ {31'd0, op};
    endfunction

    function automatic logic nan_in(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction

    assign bus.add_res   = adder_model(bus.add_a, bus.add_b, bus.add_op);
    assign bus.add_error = force_err;

    // Operands must not move while the issuer sits in HOLD.
    logic [64:0] held;
    bit          was_hold = 1'b0;
    always @(negedge clk) begin
        if (rst_n && dut.state == 2'd1) begin
            if (was_hold) begin
                n_checks++;
                if ({bus.add_a, bus.add_b, bus.add_op} !== held) begin
                    n_fail++;
                    $display("FAIL hold_stable: add ports %h, required %h", {bus.add_a, bus.add_b, bus.add_op}, held);
                end
            end else begin
                held = {bus.add_a, bus.add_b, bus.add_op};
            end
            was_hold = 1'b1;
        end else begin
            was_hold = 1'b0;
        end
    end

    // Returns right after the accepting edge with in_valid dropped.
    task automatic push_req(input logic [31:0] a, input logic [31:0] b, input logic op);
        bit ok = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        for (int i = 0; i < 400; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: in_ready stayed 0, required 1");
        end
    endtask

    // Counts rising edges until out_valid is seen (sampled 1 ns after each edge).
    task automatic wait_valid(input int max, output int cycles);
        cycles = -1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                cycles = i;
                return;
            end
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_error, bus.out_nan, bus.add_op, bus.busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {bus.in_ready, bus.out_valid, bus.out_error, bus.out_nan, bus.add_op, bus.busy});
        end
        n_checks++;
        if (bus.out_res !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_out_res: got %h, required 0", bus.out_res);
        end
        n_checks++;
        if ({bus.add_a, bus.add_b} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_add_ab: got %h, required 0", {bus.add_a, bus.add_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_in_ready: got %b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_nan_bypass();
        int cyc;
        push_req(32'h7FC0_0001, 32'h3F80_0000, 1'b0);
        wait_valid(10, cyc);
        n_checks++;
        if (cyc != 2) begin
            n_fail++;
            $display("FAIL nan_latency: got %0d cycles, required 2", cyc);
        end
        n_checks++;
        if ({bus.out_res, bus.out_nan, bus.out_error} !== {32'h7FC0_0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL nan_result: got res=%h nan=%b err=%b, required res=7fc00000 nan=1 err=0",
                     bus.out_res, bus.out_nan, bus.out_error);
        end
        n_checks++;
        if (bus.add_a !== 32'd0) begin
            n_fail++;
            $display("FAIL nan_add_a: got %h, required 0", bus.add_a);
        end
        consume();
        n_checks++;
        if ({bus.out_valid, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL nan_drain: got valid/busy=%b, required 00", {bus.out_valid, bus.busy});
        end
    endtask

    task automatic test_single_add();
        int cyc;
        push_req(32'h3F80_0000, 32'h4000_0000, 1'b0);
        wait_valid(H + 10, cyc);
        n_checks++;
        if (cyc != H + 2) begin
            n_fail++;
            $display("FAIL add_latency: got %0d cycles, required %0d", cyc, H + 2);
        end
        n_checks++;
        if ({bus.out_res, bus.out_error, bus.out_nan} !== {32'h4040_0000, 2'b00}) begin
            n_fail++;
            $display("FAIL add_result: got res=%h err=%b nan=%b, required res=40400000 err=0 nan=0",
                     bus.out_res, bus.out_error, bus.out_nan);
        end
        n_checks++;
        if ({bus.add_a, bus.add_b, bus.add_op} !== {32'h3F80_0000, 32'h4000_0000, 1'b0}) begin
            n_fail++;
            $display("FAIL add_ports: got %h, required 3f80000040000000 op 0", {bus.add_a, bus.add_b, bus.add_op});
        end
        consume();
    endtask

    task automatic test_error();
        int cyc;
        force_err = 1'b1;
        push_req(32'h4120_0000, 32'h4000_0000, 1'b1);
        wait_valid(H + 10, cyc);
        n_checks++;
        if ({bus.out_res, bus.out_error, bus.out_nan} !== {32'h0120_0001, 1'b1, 1'b0} || cyc != H + 2) begin
            n_fail++;
            $display("FAIL err_pass: got res=%h err=%b nan=%b cyc=%0d, required res=01200001 err=1 nan=0 cyc=%0d",
                     bus.out_res, bus.out_error, bus.out_nan, cyc, H + 2);
        end
        consume();
        force_err = 1'b0;
    endtask

    task automatic test_back_to_back();
        int          cyc;
        logic [31:0] first_res;
        logic [31:0] exp_res [3] = '{32'h4040_0000, 32'h7FC0_0000, 32'h7F20_0001};
        logic        exp_nan [3] = '{1'b0, 1'b1, 1'b0};
        push_req(32'h3F80_0000, 32'h4000_0000, 1'b0);
        push_req(32'h7F80_0010, 32'h4000_0000, 1'b0);
        push_req(32'h40A0_0000, 32'h3F80_0000, 1'b1);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: in_ready got %b, required 0", bus.in_ready);
        end
        wait_valid(H + 10, cyc);
        first_res = bus.out_res;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, bus.out_res} !== {1'b1, 1'b0, first_res}) begin
            n_fail++;
            $display("FAIL bp_stall: got valid=%b ready=%b res=%h, required valid=1 ready=0 res=%h",
                     bus.out_valid, bus.in_ready, bus.out_res, first_res);
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) wait_valid(H + 10, cyc);
            n_checks++;
            if (cyc < 0 || {bus.out_res, bus.out_nan} !== {exp_res[k], exp_nan[k]}) begin
                n_fail++;
                $display("FAIL bp_result%0d: got res=%h nan=%b cyc=%0d, required res=%h nan=%b",
                         k, bus.out_res, bus.out_nan, cyc, exp_res[k], exp_nan[k]);
            end
            consume();
        end
        wait_valid(2 * H, cyc);
        n_checks++;
        if (cyc != -1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_dup: extra out_valid at cycle %0d busy=%b, required none and busy 0", cyc, bus.busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen = 0;
        push_req(32'h3F80_0000, 32'h4000_0000, 1'b0);
        push_req(32'h4040_0000, 32'h3F80_0000, 1'b1);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_error, bus.out_nan, bus.add_op, bus.busy} !== 6'b0 ||
            {bus.out_res, bus.add_a, bus.add_b} !== 96'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: flags=%b res=%h a=%h b=%h, required all 0",
                     {bus.in_ready, bus.out_valid, bus.out_error, bus.out_nan, bus.add_op, bus.busy},
                     bus.out_res, bus.add_a, bus.add_b);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        n_checks++;
        if (seen != 0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_quiet: out_valid seen %0d times, in_ready=%b, required 0 and 1", seen, bus.in_ready);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        logic        nan;
    } exp_t;

    task automatic test_random_traffic();
        localparam int N = 10;
        exp_t q[$];
        int   got = 0;
        bit   drv_fail = 1'b0;
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    logic [31:0] a = $urandom;
                    logic [31:0] b = $urandom;
                    logic        op = 1'($urandom_range(0, 1));
                    bit          ok = 1'b0;
                    if ($urandom_range(0, 3) == 0) a = {1'b0, 8'hFF, 23'($urandom) | 23'd1};
                    @(negedge clk);
                    bus.in_valid = 1'b1;
                    bus.in_a = a;
                    bus.in_b = b;
                    bus.in_op = op;
                    for (int w = 0; w < 400; w++) begin
                        if (bus.in_ready) begin
                            ok = 1'b1;
                            break;
                        end
                        @(negedge clk);
                    end
                    if (!ok) begin
                        drv_fail = 1'b1;
                        break;
                    end
                    if (nan_in(a) || nan_in(b)) q.push_back('{32'h7FC0_0000, 1'b1});
                    else                        q.push_back('{adder_model(a, b, op), 1'b0});
                    @(posedge clk);
                end
                #1 bus.in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 4000 && got < N; c++) begin
                    @(negedge clk);
                    bus.out_ready = 1'($urandom_range(0, 1));
                    if (bus.out_valid && bus.out_ready) begin
                        exp_t e;
                        n_checks++;
                        if (q.size() == 0) begin
                            n_fail++;
                            $display("FAIL rand_unexpected: got res=%h, required no result", bus.out_res);
                        end else begin
                            e = q.pop_front();
                            if ({bus.out_res, bus.out_nan, bus.out_error} !== {e.res, e.nan, 1'b0}) begin
                                n_fail++;
                                $display("FAIL rand_result%0d: got res=%h nan=%b err=%b, required res=%h nan=%b err=0",
                                         got, bus.out_res, bus.out_nan, bus.out_error, e.res, e.nan);
                            end
                        end
                        got++;
                    end
                end
                @(negedge clk);
                bus.out_ready = 1'b0;
            end
        join
        n_checks++;
        if (got != N || drv_fail) begin
            n_fail++;
            $display("FAIL rand_count: got %0d results (driver stuck=%b), required %0d", got, drv_fail, N);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.in_op     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_nan_bypass();
        test_single_add();
        test_error();
        test_back_to_back();
        test_reset_mid_op();
        test_random_traffic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
